// File: rtl/lea_byte_to_block_packer.sv
// Byte-serial to 128-bit block assembler for the LEA datapath.
// Byte k of a block lands in dout[8k+7:8k]; the full block is held until the consumer takes it.
module lea_byte_to_block_packer #(
    parameter int NUM_BYTES = 16,
    parameter int BYTE_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [BYTE_W-1:0]           din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic [NUM_BYTES*BYTE_W-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [4:0]                  byte_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int BLOCK_W = NUM_BYTES * BYTE_W;

    state_t             state_q, state_d;
    logic [4:0]         byte_cnt_q, byte_cnt_d;
    logic [BLOCK_W-1:0] dout_q, dout_d;
    logic [3:0]         lane_idx;

    assign lane_idx = byte_cnt_q[3:0];

    // Lanes are only ever written in order, so no zeroing is needed between blocks.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        dout_d     = dout_q;
        if (clear) begin
            state_d    = FILL;
            byte_cnt_d = 5'd0;
            dout_d     = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (din_valid) begin
                        dout_d[32'(lane_idx)*BYTE_W +: BYTE_W] = din;
                        byte_cnt_d = byte_cnt_q + 5'd1;
                        if (byte_cnt_q == 5'(NUM_BYTES - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dout_ready) begin
                        state_d    = FILL;
                        byte_cnt_d = 5'd0;
                    end
                end
                default: begin
                    state_d    = FILL;
                    byte_cnt_d = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            byte_cnt_q <= 5'd0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            dout_q     <= dout_d;
        end
    end

    // Handshake outputs depend on registered state only.
    assign din_ready  = (state_q == FILL);
    assign dout_valid = (state_q == HOLD);
    assign dout       = dout_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_lea_byte_to_block_packer.sv
// Self-checking bench for lea_byte_to_block_packer: a directed vector table, hand-written
// corner sequences and random traffic, all compared against a queue-based block model.
module tb_lea_byte_to_block_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic [7:0]   din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [4:0]   byte_cnt;

    int checks   = 0;
    int failures = 0;

    lea_byte_to_block_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the bytes of the block being built, plus the 16 output lanes.
    logic [7:0] m_q [$];
    logic [7:0] m_lanes [16];

    function automatic logic [127:0] modelBlock();
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = m_lanes[k];
        return r;
    endfunction

    function automatic logic [127:0] seqBlock(input logic [7:0] base);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic modelStep();
        if (!rst_n || clear) begin
            m_q.delete();
            for (int k = 0; k < 16; k++) m_lanes[k] = 8'h00;
        end else if (m_q.size() == 16) begin
            if (dout_ready) m_q.delete();
        end else if (din_valid) begin
            m_lanes[m_q.size()] = din;
            m_q.push_back(din);
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        check("model_din_ready",  128'(din_ready),  128'(m_q.size() != 16));
        check("model_dout_valid", 128'(dout_valid), 128'(m_q.size() == 16));
        check("model_byte_cnt",   128'(byte_cnt),   128'(m_q.size()));
        check("model_dout",       dout,             modelBlock());
    endtask

    // Drive inputs away from the edge, advance one clock, then compare on the falling edge.
    task automatic applyStimulus(input logic r, input logic c, input logic [7:0] d,
                                 input logic dv, input logic dr);
        rst_n      = r;
        clear      = c;
        din        = d;
        din_valid  = dv;
        dout_ready = dr;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic fillBlock(input logic [7:0] base, input logic dr);
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, base + 8'(k), 1'b1, dr);
    endtask

    typedef struct {
        logic         rst_n;
        logic         clear;
        logic [7:0]   din;
        logic         din_valid;
        logic         dout_ready;
        logic         exp_din_ready;
        logic         exp_dout_valid;
        logic [4:0]   exp_cnt;
        logic         chk_dout;
        logic [127:0] exp_dout;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [127:0] blk0;
        int           zero_ready;
        int           blocks;
        logic [7:0]   next_byte;
        logic         acc;
        logic [127:0] basic_blk;

        basic_blk = 128'h0F0E0D0C0B0A09080706050403020100;

        // Basic pack as a vector table: reset, 16 bytes, handoff, then an idle cycle.
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 128'h0});
        for (int k = 0; k < 16; k++)
            vecs.push_back('{1'b1, 1'b0, 8'(k), 1'b1, 1'b1, (k != 15), (k == 15),
                             5'(k + 1), (k == 15), basic_blk});
        vecs.push_back('{1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, basic_blk});
        vecs.push_back('{1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, basic_blk});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].clear, vecs[i].din,
                          vecs[i].din_valid, vecs[i].dout_ready);
            check("tbl_din_ready",  128'(din_ready),  128'(vecs[i].exp_din_ready));
            check("tbl_dout_valid", 128'(dout_valid), 128'(vecs[i].exp_dout_valid));
            check("tbl_byte_cnt",   128'(byte_cnt),   128'(vecs[i].exp_cnt));
            if (vecs[i].chk_dout) check("tbl_dout", dout, vecs[i].exp_dout);
        end

        // Backpressure: the held block must survive 5 stalled cycles with bytes offered.
        fillBlock(8'h10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
            check("bp_dout",      dout,              128'h1F1E1D1C1B1A19181716151413121110);
            check("bp_din_ready", 128'(din_ready),   128'd0);
            check("bp_byte_cnt",  128'(byte_cnt),    128'd16);
        end
        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
        check("bp_release_ready", 128'(din_ready), 128'd1);
        check("bp_release_cnt",   128'(byte_cnt),  128'd0);

        // Gapped input: only the valid cycles may count.
        for (int i = 0; i < 32; i++)
            applyStimulus(1'b1, 1'b0, 8'hA0 + 8'(i / 2), (i % 2) == 0, 1'b0);
        check("gap_dout", dout, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        check("gap_cnt",  128'(byte_cnt), 128'd16);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset in the middle of a block discards the partial data.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'hC7, 1'b1, 1'b0);
        check("rst_cnt",   128'(byte_cnt),   128'd0);
        check("rst_dout",  dout,             128'd0);
        check("rst_valid", 128'(dout_valid), 128'd0);
        fillBlock(8'h30, 1'b0);
        check("rst_refill_dout", dout, 128'h3F3E3D3C3B3A39383736353433323130);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Clear wins over a handoff, and over a byte offered during FILL.
        fillBlock(8'h60, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        check("clr_hold_valid", 128'(dout_valid), 128'd0);
        check("clr_hold_dout",  dout,             128'd0);
        check("clr_hold_cnt",   128'(byte_cnt),   128'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h70 + 8'(i), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        check("clr_fill_cnt",  128'(byte_cnt), 128'd0);
        check("clr_fill_dout", dout,           128'd0);

        // Back-to-back blocks: one din_ready=0 cycle between them, nothing lost or doubled.
        zero_ready = 0;
        blocks     = 0;
        next_byte  = 8'h40;
        blk0       = '0;
        for (int i = 0; i < 34; i++) begin
            acc = (m_q.size() != 16);
            applyStimulus(1'b1, 1'b0, next_byte, 1'b1, 1'b1);
            if (acc) next_byte = next_byte + 8'd1;
            if (i < 32 && !din_ready) zero_ready++;
            if (dout_valid) begin
                if (blocks == 0) blk0 = dout;
                else check("b2b_blk1", dout, seqBlock(8'h50));
                blocks++;
            end
        end
        check("b2b_blk0",       blk0,              seqBlock(8'h40));
        check("b2b_blocks",     128'(blocks),      128'd2);
        check("b2b_zero_ready", 128'(zero_ready),  128'd1);
        check("b2b_next_byte",  128'(next_byte),   128'h60);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 59) == 0,
                          8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lea_byte_to_block_packer.md
Name: lea_byte_to_block_packer

Overview:
- Byte-serial to 128-bit block assembler for the LEA datapath.
- Inverse of the 128-bit to 16x8 byte split: byte k received in sequence lands in block bits [8k+7:8k]. The first byte goes to [7:0] and the sixteenth to [127:120].
- Sits between a byte-wide source (UART, bus bridge or key/plaintext loader) and the 128-bit LEA round core.
- Valid/ready on both sides.

Parameters:
- NUM_BYTES, 16: bytes per block. The LEA block is fixed at 16; other values are unsupported.
- BYTE_W, 8: lane width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous abort: discards any partial or held block.
- din  input  8  incoming byte.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  packer can accept a byte.
- dout  output  128  assembled block; lane k = dout[8k+7:8k].
- dout_valid  output  1  dout holds a complete block.
- dout_ready  input  1  consumer takes the block.
- byte_cnt  output  5  bytes accepted into the current block, 0..16.

Behaviour:
- Clock and reset: single clock domain; all state updates on the rising edge of clk.
- rst_n=0 at a clock edge forces:
  - state=FILL, byte_cnt=0, dout=0, dout_valid=0.
  - din_ready=1 from the first cycle after reset is released.
  - This applies mid-fill or mid-hold; any partial block is lost.
- Priority order: rst_n, then clear, then normal operation.
- clear=1 (with rst_n=1) has the same effect as reset on the next edge, including dout=0.
  - A byte presented while clear=1 is not accepted, even if din_valid=1.
  - A block presented while clear=1 is dropped, even if dout_ready=1.
- State FILL:
  - din_ready=1 and dout_valid=0.
  - Accept occurs when din_valid && din_ready.
  - On accept: lane[byte_cnt] <= din and byte_cnt <= byte_cnt+1. Other lanes keep their values.
  - Lanes are not zeroed at the start of a block; all 16 are overwritten before dout_valid rises.
  - On the accept with byte_cnt==15: byte_cnt <= 16 and state <= HOLD.
  - din_valid=0 cycles (gaps) change nothing.
- State HOLD:
  - din_ready=0 and dout_valid=1.
  - dout and byte_cnt hold, unchanged while dout_valid && !dout_ready.
  - On dout_valid && dout_ready: state <= FILL, byte_cnt <= 0, dout_valid <= 0.
  - dout keeps its last value after handoff and is not cleared.
  - A byte presented in the handoff cycle is not accepted, since din_ready=0.
- Latency and throughput:
  - dout_valid rises in the cycle after the 16th byte accept.
  - With dout_ready held high, the block transfers in the first HOLD cycle.
  - Throughput is 16 bytes per 17 cycles.
- Outputs:
  - din_ready, dout_valid and byte_cnt are decoded from registered state only.
  - There is no combinational path from din_valid or dout_ready to any output.
- byte_cnt never exceeds 16 and never wraps.
- din_valid/din are ignored when din_ready=0; the upstream must hold the byte.

Test Plan:
- Basic pack: reset, then stream din=0x00..0x0F with din_valid=1 and dout_ready=1.
  - dout_valid rises one cycle after the 16th accept.
  - dout = 0x0F0E0D0C0B0A09080706050403020100 for one cycle.
  - byte_cnt reads 0..16, then returns to 0.
- Backpressure: fill with 0x10..0x1F while dout_ready=0 for 5 cycles.
  - dout = 0x1F1E...11_10 stays stable with dout_valid=1 and din_ready=0 for 5 cycles.
  - Bytes offered during HOLD are not consumed.
  - Raising dout_ready gives one transfer, then din_ready=1 on the next cycle.
- Gapped input: 16 bytes 0xA0..0xAF with din_valid toggled 1,0,1,0...
  - Exactly 16 accepts occur; byte_cnt increments only on valid cycles.
  - Final dout = 0xAFAE...A1A0.
- Reset mid-fill: accept 7 bytes, then rst_n=0 for one cycle.
  - byte_cnt=0, dout=0, dout_valid=0.
  - Next 16 bytes 0x30..0x3F produce 0x3F3E...3130 with no stale lanes.
- Clear in HOLD: complete a block with dout_ready=0, then assert clear=1 together with dout_ready=1.
  - No transfer is counted; dout_valid=0, dout=0 and byte_cnt=0 next cycle.
  - Clear during FILL with din_valid=1 is likewise not accepted.
- Back-to-back: two consecutive 16-byte bursts with dout_ready=1 and din_valid held high.
  - Two blocks are delivered.
  - Exactly one cycle has din_ready=0 between them; no byte is lost or duplicated.
